// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low hex patterns
// (g..a), the blank pattern, FSM encoding and anode classification helpers.
package seg_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        AN_GAP    = 2'd0,
        AN_SINGLE = 2'd1,
        AN_MULTI  = 2'd2
    } an_class_e;

    function automatic an_class_e an_classify(input logic [3:0] an);
        an_class_e cls;
        case (an)
            4'b1111:                             cls = AN_GAP;
            4'b1110, 4'b1101, 4'b1011, 4'b0111: cls = AN_SINGLE;
            default:                             cls = AN_MULTI;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low segment pattern into a hex value.
// legal_o covers both hex glyphs and the all-off blank pattern.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    // Pattern lookup; anything outside the table or blank is illegal
    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        value_o = 4'h0;
        case (seg_i)
            SEG_HEX_0: value_o = 4'h0;
            SEG_HEX_1: value_o = 4'h1;
            SEG_HEX_2: value_o = 4'h2;
            SEG_HEX_3: value_o = 4'h3;
            SEG_HEX_4: value_o = 4'h4;
            SEG_HEX_5: value_o = 4'h5;
            SEG_HEX_6: value_o = 4'h6;
            SEG_HEX_7: value_o = 4'h7;
            SEG_HEX_8: value_o = 4'h8;
            SEG_HEX_9: value_o = 4'h9;
            SEG_HEX_A: value_o = 4'hA;
            SEG_HEX_B: value_o = 4'hB;
            SEG_HEX_C: value_o = 4'hC;
            SEG_HEX_D: value_o = 4'hD;
            SEG_HEX_E: value_o = 4'hE;
            SEG_HEX_F: value_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Observes a multiplexed seven-segment bus and rebuilds the four displayed
// digits, accepting a position only after its pattern is stable long enough.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_led,
    input  logic [3:0] An,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic [3:0] blank,
    output logic       update,
    output logic       frame_done,
    output logic       err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic [6:0]        seg_q, prev_seg_q;
    logic [3:0]        an_q, prev_an_q;
    scan_state_e       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0][3:0]   digits_q, digits_d;
    logic [3:0]        valid_q, valid_d;
    logic [3:0]        blank_q, blank_d;
    logic              update_q, update_d;
    logic              frame_q, frame_d;
    logic              err_q, err_d;

    an_class_e         an_class_s;
    logic [1:0]        idx_s;
    logic              sample_diff_s;
    logic              accept_s;
    logic [3:0]        mask_new_s;
    logic              dec_legal_s;
    logic              dec_blank_s;
    logic [3:0]        dec_value_s;

    seg7_to_hex u_dec (
        .seg_i   (seg_q),
        .legal_o (dec_legal_s),
        .blank_o (dec_blank_s),
        .value_o (dec_value_s)
    );

    assign an_class_s    = an_classify(an_q);
    assign idx_s         = an_index(an_q);
    assign sample_diff_s = (an_q != prev_an_q) || (seg_q != prev_seg_q);

    // Run tracking FSM plus accept/update/frame bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        blank_d    = blank_q;
        update_d   = 1'b0;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        accept_s   = 1'b0;
        mask_new_s = mask_q | (4'b0001 << idx_s);

        case (an_class_s)
            AN_SINGLE: begin
                if (sample_diff_s) begin
                    state_d = ST_TRACK;
                    cnt_d   = 8'd1;
                end else begin
                    case (state_q)
                        ST_TRACK: begin
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_d == STABLE_C) begin
                                accept_s = 1'b1;
                                state_d  = ST_HOLD;
                            end else begin
                                accept_s = 1'b0;
                            end
                        end
                        // Counter saturates in HOLD: a held pattern is accepted once
                        ST_HOLD: begin
                            state_d = ST_HOLD;
                        end
                        default: begin
                            state_d = ST_TRACK;
                            cnt_d   = 8'd1;
                        end
                    endcase
                end
            end
            AN_MULTI: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (accept_s) begin
            if (dec_legal_s && dec_blank_s) begin
                blank_d[idx_s] = 1'b1;
                valid_d[idx_s] = 1'b1;
            end else if (dec_legal_s) begin
                digits_d[idx_s] = dec_value_s;
                blank_d[idx_s]  = 1'b0;
                valid_d[idx_s]  = 1'b1;
            end else begin
                err_d          = 1'b1;
                valid_d[idx_s] = 1'b0;
            end
            update_d = (digits_d != digits_q) || (blank_d != blank_q) || (valid_d != valid_q);
            if (mask_new_s == 4'b1111) begin
                frame_d = 1'b1;
                mask_d  = 4'b0000;
            end else begin
                mask_d  = mask_new_s;
            end
        end else begin
            mask_d = mask_q;
        end
    end

    // Input sample stage and all state/output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
            prev_seg_q <= SEG_BLANK;
            prev_an_q  <= 4'hF;
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            mask_q     <= 4'b0000;
            digits_q   <= 16'h0000;
            valid_q    <= 4'b0000;
            blank_q    <= 4'b1111;
            update_q   <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_q      <= seg_led;
            an_q       <= An;
            prev_seg_q <= seg_q;
            prev_an_q  <= an_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            update_q   <= update_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign digit0      = digits_q[0];
    assign digit1      = digits_q[1];
    assign digit2      = digits_q[2];
    assign digit3      = digits_q[3];
    assign digit_valid = valid_q;
    assign blank       = blank_q;
    assign update      = update_q;
    assign frame_done  = frame_q;
    assign err         = err_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment driver: samples the scanned `seg_led`/`An` bus and reconstructs the four displayed hex digits, each with its own valid/blank status. Used as an on-chip loopback monitor next to the display path in the timer top, and as the display observer in system benches. A digit is accepted only after its pattern has been held for a programmable number of consecutive cycles. Illegal bus conditions are flagged.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a digit; legal range 2..255.
- `clk` in 1: system clock, same domain as the display driver.
- `reset` in 1: synchronous, active-low reset.
- `seg_led` in 7: segment lines, active-low; bit0=a … bit6=g.
- `An` in 4: anode enables, active-low; `An[0]` = rightmost digit (digit0).
- `digit0..digit3` out 4 each: last accepted hex value per position.
- `digit_valid` out 4: bit i set once position i has accepted a decodable pattern.
- `blank` out 4: bit i set when position i last showed all segments off.
- `update` out 1: one-cycle pulse when any accepted digit/blank value differs from the stored value.
- `frame_done` out 1: one-cycle pulse when all four positions have been accepted since the previous pulse.
- `err` out 1: one-cycle pulse on an illegal anode or segment condition.

## Operation
- Input stage: `seg_led`/`An` registered once (sample S). All logic below acts on S.
- Anode classification of S: exactly one `An` bit low gives idx; all high gives gap; two or more low gives a multi error.
- FSM states:
  - IDLE: no run in progress.
  - TRACK: counting a run.
  - HOLD: run accepted, waiting for change.
- FSM transitions:
  - gap in any state: go to IDLE, run counter = 0.
  - multi in any state: `err` pulse, go to IDLE, run counter = 0.
  - single anode with (idx, seg) ≠ previous sample: go to TRACK, counter = 1.
  - equal in TRACK: counter++. When counter reaches `STABLE_CYCLES`, accept and go to HOLD.
  - equal in HOLD: no action. The counter saturates; there is no re-acceptance.
- Accept for position idx:
  - pattern 0x7F: `blank[idx]`=1, `digit_valid[idx]`=1, digit value unchanged.
  - hex pattern 0–F: digit=value, `blank[idx]`=0, `digit_valid[idx]`=1.
  - any other pattern: `err` pulse, `digit_valid[idx]`=0, digit unchanged.
  - `update` pulses if digit, blank or valid of idx changed.
  - idx is set in the seen-mask. When the mask becomes 4'b1111, `frame_done` pulses and the mask clears in the same cycle.
- Hex table, active-low, g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events: an `err` from an undecodable accept and `frame_done` can pulse in the same cycle. The mask bit is set for undecodable accepts as well.
- Reset mid-run: discards the run, the mask and all outputs.

## Timing
- Reset values:
  - `digit0..3`=0, `digit_valid`=0, `blank`=4'b1111
  - `update`=0, `frame_done`=0, `err`=0
  - FSM=IDLE, mask=0, counter=0, sample register = {7'h7F, 4'hF}.
- Latency: a pattern first captured at edge k is accepted, and outputs are updated, at edge k+`STABLE_CYCLES`.
- A pattern held fewer than `STABLE_CYCLES` samples is never accepted.
- `err` for a multi condition is asserted on the edge after S shows it, i.e. 2 edges after the bus condition first appears.
- All outputs are registered. Pulses last exactly one cycle.

## Structure
- Shared package `seg_pkg`: the 16 hex segment constants, `SEG_BLANK`=7'h7F, and the FSM state encoding.
- Sub-module `seg7_to_hex`: combinational 7-bit pattern to {legal, blank, value[3:0]}.
- The FSM, counter, mask and output registers live in the top.

## Test plan
- Reset: hold `reset`=0 for 3 cycles. Required: `blank`=F, `digit_valid`=0, all pulses 0.
- Hold An=1110, seg=12 for 4 cycles. Required: `digit0`=5 and `digit_valid[0]`=1 at the 4th edge, with `update` pulsing once. Holding 3 cycles must leave all outputs unchanged.
- Scan "1","2","3","4" with 6 cycles each, digit0 first and 1-cycle gaps between digits. Required: `frame_done` pulses once, after digit3 is accepted, and `digit3..0`=4,3,2,1.
- Drive An=1100 for 1 cycle. Required: `err` pulse 2 edges later, FSM returns to IDLE, and digits are unchanged.
- Drive digit1 with seg=7F. Required: `blank[1]`=1 and `digit_valid[1]`=1. Then drive seg=55 on digit1. Required: `err` pulse and `digit_valid[1]`=0.
- Assert `reset` 2 cycles into a 4-cycle run. Required: no accept occurs, and all outputs return to reset values on the next edge.
